// File: rtl/fetch_sequencer_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
// ST_TRAP exists only when FETCH_MISALIGN_TRAP_EN is defined.
package fetch_sequencer_pkg;

    localparam logic [6:0]  OPC_JAL   = 7'b1101111;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        ST_TRAP = 2'd2
`endif
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [1:0] lsbs);
        return lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_sequencer_next_pc.sv
// Combinational successor-PC logic: decodes the JAL J-immediate and produces the
// sequential or jump target. Kept separate so a branch predictor can reuse it.
module fetch_next_pc
    import fetch_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_next_pc,
    output logic            o_is_jal
);

    logic [XLEN-1:0] w_jimm;
    logic            w_unused_rd;

    assign w_jimm = {{(XLEN-20){i_instr[31]}}, i_instr[19:12], i_instr[20],
                     i_instr[30:21], 1'b0};

    assign o_is_jal  = (i_instr[6:0] == OPC_JAL);
    assign o_next_pc = i_pc + (o_is_jal ? w_jimm : XLEN'(4));

    // The destination register field is irrelevant to fetch.
    assign w_unused_rd = ^i_instr[11:7];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch stage: PC register, local JAL resolution, downstream redirects and
// a one-entry output register to decode. Optional misalignment trap: FETCH_MISALIGN_TRAP_EN.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              MEM_WORDS    = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [XLEN-1:0]              o_imem_addr,
    output logic [$clog2(MEM_WORDS)-1:0] o_imem_word_idx,
    input  logic [31:0]                  i_imem_rdata,
    output logic [31:0]                  o_instr_out,
    output logic [XLEN-1:0]              o_instr_pc,
    output logic                         o_instr_valid,
    input  logic                         i_instr_ready,
    input  logic                         i_redirect_valid,
    input  logic [XLEN-1:0]              i_redirect_target
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic                         o_misalign_trap
`endif
);

    localparam int IDXW = $clog2(MEM_WORDS);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr_out;
    logic [XLEN-1:0] r_instr_pc;
    logic            r_instr_valid;

    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic [31:0]     w_instr_nxt;
    logic [XLEN-1:0] w_instr_pc_nxt;
    logic            w_valid_nxt;
    logic            w_fire;
    logic [XLEN-1:0] w_next_pc;
    logic            w_unused_is_jal;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic            r_misalign_trap;
    logic            w_trap_nxt;
`else
    logic            w_unused_lsbs;
`endif

    fetch_next_pc #(
        .XLEN (XLEN)
    ) u_next_pc (
        .i_pc      (r_pc),
        .i_instr   (i_imem_rdata),
        .o_next_pc (w_next_pc),
        .o_is_jal  (w_unused_is_jal)
    );

    assign w_fire = !r_instr_valid || i_instr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_VECTOR;
            r_instr_out   <= NOP_INSTR;
            r_instr_pc    <= RESET_VECTOR;
            r_instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_misalign_trap <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr_out   <= w_instr_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_instr_valid <= w_valid_nxt;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_misalign_trap <= w_trap_nxt;
`endif
        end
    end

    // Redirect outranks fetch; the word read in a redirect cycle is simply dropped.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr_out;
        w_instr_pc_nxt = r_instr_pc;
        w_valid_nxt    = r_instr_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
        w_trap_nxt     = r_misalign_trap;
`endif
        case (r_state)
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_TRAP: begin
                w_valid_nxt = 1'b0;
            end
`endif
            default: begin
                if (i_redirect_valid) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
                    w_pc_nxt = i_redirect_target;
                    if (is_misaligned(i_redirect_target[1:0])) begin
                        w_state_nxt = ST_TRAP;
                        w_trap_nxt  = 1'b1;
                    end
`else
                    w_pc_nxt = {i_redirect_target[XLEN-1:2], 2'b00};
`endif
                end else if (w_fire) begin
                    w_instr_nxt    = i_imem_rdata;
                    w_instr_pc_nxt = r_pc;
                    w_valid_nxt    = 1'b1;
                    w_state_nxt    = ST_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
                    w_pc_nxt = w_next_pc;
                    // Sequential successors are always aligned, so only a JAL can land here.
                    if (is_misaligned(w_next_pc[1:0])) begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = ST_TRAP;
                        w_trap_nxt  = 1'b1;
                    end
`else
                    w_pc_nxt = {w_next_pc[XLEN-1:2], 2'b00};
`endif
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
        endcase
    end

`ifndef FETCH_MISALIGN_TRAP_EN
    assign w_unused_lsbs = ^{i_redirect_target[1:0], w_next_pc[1:0]};
`endif

    assign o_imem_addr     = r_pc;
    assign o_imem_word_idx = r_pc[2 +: IDXW];
    assign o_instr_out     = r_instr_out;
    assign o_instr_pc      = r_instr_pc;
    assign o_instr_valid   = r_instr_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign o_misalign_trap = r_misalign_trap;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus pushes expected (pc, instr) pairs,
// a negedge monitor pops them on every accepted handshake. Covers FETCH_MISALIGN_TRAP_EN too.
module tb_fetch_sequencer;

    localparam int          XLEN         = 32;
    localparam int          MEM_WORDS    = 64;
    localparam int          IDXW         = 6;
    localparam logic [31:0] RESET_VECTOR = 32'h0;
    localparam logic [31:0] NOP          = 32'h0000_0013;
    localparam logic [31:0] JAL_P8       = 32'h0080_006F;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } expItem_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [31:0]     imemAddr;
    logic [IDXW-1:0] imemWordIdx;
    logic [31:0]     imemRdata;
    logic [31:0]     instrOut;
    logic [31:0]     instrPc;
    logic            instrValid;
    logic            instrReady = 1'b0;
    logic            redirectValid = 1'b0;
    logic [31:0]     redirectTarget = 32'h0;
    logic            misalignTrap;

    logic [31:0] mem [MEM_WORDS];
    expItem_t    expQ [$];
    int          checks = 0;
    int          failures = 0;

    assign imemRdata = mem[imemWordIdx];

`ifndef FETCH_MISALIGN_TRAP_EN
    assign misalignTrap = 1'b0;
`endif

    fetch_sequencer #(
        .XLEN         (XLEN),
        .MEM_WORDS    (MEM_WORDS),
        .RESET_VECTOR (RESET_VECTOR)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .o_imem_addr       (imemAddr),
        .o_imem_word_idx   (imemWordIdx),
        .i_imem_rdata      (imemRdata),
        .o_instr_out       (instrOut),
        .o_instr_pc        (instrPc),
        .o_instr_valid     (instrValid),
        .i_instr_ready     (instrReady),
        .i_redirect_valid  (redirectValid),
        .i_redirect_target (redirectTarget)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .o_misalign_trap   (misalignTrap)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] addiWord(input int i);
        return {12'(i), 5'd0, 3'd0, 5'd1, 7'h13};
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [31:0] pc, input logic [31:0] instr);
        expQ.push_back('{pc: pc, instr: instr});
    endtask

    task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] target);
        instrReady     = ready;
        redirectValid  = redir;
        redirectTarget = target;
    endtask

    // Reset for two edges, then check the reset state before releasing.
    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        stepCycle();
        stepCycle();
        checkOutput("reset_valid", {31'd0, instrValid}, 32'd0);
        checkOutput("reset_instr", instrOut, NOP);
        checkOutput("reset_pc", instrPc, RESET_VECTOR);
        checkOutput("reset_addr", imemAddr, RESET_VECTOR);
        checkOutput("reset_trap", {31'd0, misalignTrap}, 32'd0);
        reset = 1'b0;
    endtask

    // Keep ready high until the monitor has consumed every expected entry.
    task automatic drain();
        int n = 0;
        instrReady = 1'b1;
        while (expQ.size() > 0 && n < 64) begin
            @(posedge clk);
            n++;
        end
        #1;
        instrReady = 1'b0;
        checks++;
        if (expQ.size() > 0) begin
            failures++;
            $display("[TB] FAIL drain_timeout: %0d entries left, required 0", expQ.size());
            expQ.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!reset && instrValid && instrReady) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_accept: pc 0x%08h with empty scoreboard", instrPc);
            end else begin
                expItem_t e;
                e = expQ.pop_front();
                checkOutput("sb_pc", instrPc, e.pc);
                checkOutput("sb_instr", instrOut, e.instr);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = addiWord(i);

        // Straight-line fetch, then a 3-cycle stall on pc 8.
        doReset();
        pushExp(32'h0, mem[0]);
        pushExp(32'h4, mem[1]);
        instrReady = 1'b1;
        stepCycle();
        checkOutput("first_valid", {31'd0, instrValid}, 32'd1);
        checkOutput("first_pc", instrPc, 32'h0);
        drain();
        for (int k = 0; k < 3; k++) begin
            stepCycle();
            checkOutput("hold_valid", {31'd0, instrValid}, 32'd1);
            checkOutput("hold_pc", instrPc, 32'h8);
            checkOutput("hold_instr", instrOut, mem[2]);
            checkOutput("hold_addr", imemAddr, 32'hC);
        end
        pushExp(32'h8, mem[2]);
        pushExp(32'hC, mem[3]);
        pushExp(32'h10, mem[4]);
        drain();

        // JAL +8 at pc 4, reset taken while holding.
        mem[1] = JAL_P8;
        doReset();
        pushExp(32'h0, mem[0]);
        pushExp(32'h4, JAL_P8);
        pushExp(32'hC, mem[3]);
        pushExp(32'h10, mem[4]);
        drain();

        // Redirect while holding pc 0x14.
        applyStimulus(1'b0, 1'b1, 32'h40);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("redir_flush", {31'd0, instrValid}, 32'd0);
        checkOutput("redir_addr", imemAddr, 32'h40);
        stepCycle();
        checkOutput("redir_valid", {31'd0, instrValid}, 32'd1);
        checkOutput("redir_pc", instrPc, 32'h40);
        checkOutput("redir_instr", instrOut, mem[16]);
        pushExp(32'h40, mem[16]);
        pushExp(32'h44, mem[17]);
        drain();

        // Word index wraps past the end of memory; PC keeps counting.
        applyStimulus(1'b0, 1'b1, 32'hFC);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("wrap_idx_last", 32'(imemWordIdx), 32'd63);
        stepCycle();
        checkOutput("wrap_pc", instrPc, 32'hFC);
        checkOutput("wrap_addr", imemAddr, 32'h100);
        checkOutput("wrap_idx_zero", 32'(imemWordIdx), 32'd0);
        pushExp(32'hFC, mem[63]);
        pushExp(32'h100, mem[0]);
        pushExp(32'h104, JAL_P8);
        pushExp(32'h10C, mem[3]);
        drain();

        // Misaligned redirect target.
        applyStimulus(1'b0, 1'b1, 32'h42);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput("trap_set", {31'd0, misalignTrap}, 32'd1);
        checkOutput("trap_valid", {31'd0, instrValid}, 32'd0);
        checkOutput("trap_addr", imemAddr, 32'h42);
        applyStimulus(1'b1, 1'b1, 32'h80);
        for (int k = 0; k < 3; k++) stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("trap_sticky", {31'd0, misalignTrap}, 32'd1);
        checkOutput("trap_still_invalid", {31'd0, instrValid}, 32'd0);
        checkOutput("trap_pc_frozen", imemAddr, 32'h42);
`else
        checkOutput("align_flush", {31'd0, instrValid}, 32'd0);
        checkOutput("align_addr", imemAddr, 32'h40);
        stepCycle();
        checkOutput("align_valid", {31'd0, instrValid}, 32'd1);
        checkOutput("align_pc", instrPc, 32'h40);
`endif

        // Reset and redirect together: reset wins.
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'h80);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        checkOutput("rst_redir_addr", imemAddr, RESET_VECTOR);
        checkOutput("rst_redir_valid", {31'd0, instrValid}, 32'd0);
        checkOutput("rst_redir_trap", {31'd0, misalignTrap}, 32'd0);
        stepCycle();
        checkOutput("rst_redir_first_pc", instrPc, RESET_VECTOR);
        checkOutput("rst_redir_first_valid", {31'd0, instrValid}, 32'd1);

        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL sb_empty: %0d entries left, required 0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
